// File: rtl/add_pkg.sv
// Shared constants, state encoding and flag helpers for the 16-bit
// accumulating adder.
package add_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Even parity: 1 when the vector holds an even number of ones.
    function automatic logic even_parity(input logic [ADD_WIDTH-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/add16_flags.sv
// Combinational 16-bit adder producing the sum and the five status flags
// (sign, zero, carry-out, even parity, signed overflow).
module add16_flags
    import add_pkg::*;
(
    input  logic [ADD_WIDTH-1:0] X,
    input  logic [ADD_WIDTH-1:0] Y,
    output logic [ADD_WIDTH-1:0] Z,
    output logic                 Sign,
    output logic                 Zero,
    output logic                 Carry,
    output logic                 Parity,
    output logic                 Overflow
);

    logic [ADD_WIDTH:0] w_sum;

    // 17-bit add and flag decode
    always_comb begin
        w_sum    = {1'b0, X} + {1'b0, Y};
        Z        = w_sum[ADD_WIDTH-1:0];
        Carry    = w_sum[ADD_WIDTH];
        Sign     = w_sum[ADD_WIDTH-1];
        Zero     = ~|w_sum[ADD_WIDTH-1:0];
        Parity   = even_parity(w_sum[ADD_WIDTH-1:0]);
        // Signed overflow: both operands share a sign the result does not have.
        Overflow = (X[ADD_WIDTH-1] & Y[ADD_WIDTH-1] & ~w_sum[ADD_WIDTH-1]) |
                   (~X[ADD_WIDTH-1] & ~Y[ADD_WIDTH-1] & w_sum[ADD_WIDTH-1]);
    end

endmodule

// File: rtl/add_accumulator.sv
// Burst accumulator: sums `len` operands taken over a valid/ready handshake,
// feeding the adder output back as its X operand, then pulses done.
module add_accumulator
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CNT_W = ADD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] Z,
    output logic             Sign,
    output logic             Zero,
    output logic             Carry,
    output logic             Parity,
    output logic             Overflow,
    output logic             CarryAny,
    output logic             OvfAny,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    acc_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_z;
    logic             r_sign;
    logic             r_zero;
    logic             r_carry;
    logic             r_parity;
    logic             r_ovf;
    logic             r_cany;
    logic             r_oany;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_sum;
    logic             w_sign;
    logic             w_zero;
    logic             w_carry;
    logic             w_parity;
    logic             w_ovf;

    add16_flags u_add (
        .X        (r_z),
        .Y        (in_data),
        .Z        (w_sum),
        .Sign     (w_sign),
        .Zero     (w_zero),
        .Carry    (w_carry),
        .Parity   (w_parity),
        .Overflow (w_ovf)
    );

    // Burst FSM with accumulator, flag, sticky and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= CNT_ZERO;
            r_z        <= 16'h0000;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_parity   <= 1'b0;
            r_ovf      <= 1'b0;
            r_cany     <= 1'b0;
            r_oany     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_z      <= 16'h0000;
                        r_sign   <= 1'b0;
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_cany   <= 1'b0;
                        r_oany   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= len;
                        if (len != CNT_ZERO) begin
                            r_zero     <= 1'b0;
                            r_parity   <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= ACC;
                        end else begin
                            // An empty burst reports the flags of a zero sum.
                            r_zero   <= 1'b1;
                            r_parity <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        r_z      <= w_sum;
                        r_sign   <= w_sign;
                        r_zero   <= w_zero;
                        r_carry  <= w_carry;
                        r_parity <= w_parity;
                        r_ovf    <= w_ovf;
                        r_cany   <= r_cany | w_carry;
                        r_oany   <= r_oany | w_ovf;
                        r_cnt    <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_state <= ACC;
                        end
                    end else begin
                        r_state <= ACC;
                    end
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign Z        = r_z;
    assign Sign     = r_sign;
    assign Zero     = r_zero;
    assign Carry    = r_carry;
    assign Parity   = r_parity;
    assign Overflow = r_ovf;
    assign CarryAny = r_cany;
    assign OvfAny   = r_oany;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: directed table, hand-written
// reset/stray-start sequences and random bursts against an arithmetic model.
module tb_add_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] Z;
    logic        Sign, Zero, Carry, Parity, Overflow, CarryAny, OvfAny;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_z;
    bit m_sign, m_zero, m_carry, m_par, m_ovf, m_cany, m_oany;

    typedef struct {
        int          len;
        logic [15:0] ops [4];
        int          gap;
        logic [15:0] exp_z;
        logic [6:0]  exp_flags;  // {Sign,Zero,Carry,Parity,Overflow,CarryAny,OvfAny}
    } vec_t;

    vec_t vecs [5];

    add_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .Z(Z), .Sign(Sign), .Zero(Zero), .Carry(Carry), .Parity(Parity),
        .Overflow(Overflow), .CarryAny(CarryAny), .OvfAny(OvfAny),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] dut_flags();
        return {Sign, Zero, Carry, Parity, Overflow, CarryAny, OvfAny};
    endfunction

    function automatic logic [6:0] model_flags();
        return {m_sign, m_zero, m_carry, m_par, m_ovf, m_cany, m_oany};
    endfunction

    task automatic model_clear(input bit empty_burst);
        m_z = 0; m_sign = 0; m_carry = 0; m_ovf = 0; m_cany = 0; m_oany = 0;
        m_zero = empty_burst; m_par = empty_burst;
    endtask

    task automatic model_add(input logic [15:0] op);
        int total, sa, sb, sr;
        total = m_z + int'(op);
        sa = (m_z >= 32768) ? m_z - 65536 : m_z;
        sb = (int'(op) >= 32768) ? int'(op) - 65536 : int'(op);
        sr = sa + sb;
        m_carry = (total > 65535);
        m_z     = total % 65536;
        m_ovf   = (sr > 32767) || (sr < -32768);
        m_sign  = (m_z >= 32768);
        m_zero  = (m_z == 0);
        m_par   = (($countones(m_z) % 2) == 0);
        m_cany  = m_cany | m_carry;
        m_oany  = m_oany | m_ovf;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".Z"}, 32'(Z), 32'(m_z));
        chk({tag, ".flags"}, 32'(dut_flags()), 32'(model_flags()));
    endtask

    task automatic begin_burst(input int l);
        start = 1'b1;
        len   = 8'(l);
        tick;
        start = 1'b0;
        len   = 8'd0;
        model_clear(l == 0);
        chk("start.busy", 32'(busy), 32'd1);
        chk("start.in_ready", 32'(in_ready), (l != 0) ? 32'd1 : 32'd0);
        chk("start.done", 32'(done), (l == 0) ? 32'd1 : 32'd0);
        if (l == 0) check_model("empty");
    endtask

    task automatic accept_op(input logic [15:0] op, input int gap, input bit stray, input bit last);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 16'(g * 16'h1111);
            tick;
            chk("gap.in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = op;
        start    = stray;
        len      = 8'd1;
        tick;
        in_valid = 1'b0;
        start    = 1'b0;
        len      = 8'd0;
        model_add(op);
        check_model("accept");
        chk("accept.done", 32'(done), last ? 32'd1 : 32'd0);
        chk("accept.in_ready", 32'(in_ready), last ? 32'd0 : 32'd1);
    endtask

    task automatic end_burst(input bit stray);
        start = stray;
        len   = 8'd5;
        tick;
        start = 1'b0;
        len   = 8'd0;
        chk("end.done", 32'(done), 32'd0);
        chk("end.busy", 32'(busy), 32'd0);
        chk("end.in_ready", 32'(in_ready), 32'd0);
        check_model("hold");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 16'h0000;
        vecs[0] = '{len: 3, ops: '{16'h0001, 16'h0002, 16'h0003, 16'h0000}, gap: 0,
                    exp_z: 16'h0006, exp_flags: 7'b0001000};
        vecs[1] = '{len: 2, ops: '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000}, gap: 0,
                    exp_z: 16'h8000, exp_flags: 7'b1000101};
        vecs[2] = '{len: 3, ops: '{16'hFFFF, 16'h0001, 16'h0005, 16'h0000}, gap: 2,
                    exp_z: 16'h0005, exp_flags: 7'b0001010};
        vecs[3] = '{len: 0, ops: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, gap: 0,
                    exp_z: 16'h0000, exp_flags: 7'b0101000};
        vecs[4] = '{len: 4, ops: '{16'h8000, 16'h8000, 16'h0001, 16'h0001}, gap: 1,
                    exp_z: 16'h0002, exp_flags: 7'b0000011};

        tick; tick;
        rst = 1'b0;
        chk("reset.Z", 32'(Z), 32'd0);
        chk("reset.flags", 32'(dut_flags()), 32'd0);
        chk("reset.ctrl", {29'd0, busy, done, in_ready}, 32'd0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            begin_burst(vecs[i].len);
            for (int j = 0; j < vecs[i].len; j++)
                accept_op(vecs[i].ops[j], vecs[i].gap, 1'b0, j == vecs[i].len - 1);
            end_burst(1'b0);
            chk($sformatf("vec%0d.Z", i), 32'(Z), 32'(vecs[i].exp_z));
            chk($sformatf("vec%0d.flags", i), 32'(dut_flags()), 32'(vecs[i].exp_flags));
        end

        // Reset in the middle of a burst with in_valid held high
        begin_burst(4);
        accept_op(16'h0010, 0, 1'b0, 1'b0);
        accept_op(16'h0020, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0040;
        rst      = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst.Z", 32'(Z), 32'd0);
        chk("midrst.flags", 32'(dut_flags()), 32'd0);
        chk("midrst.ctrl", {29'd0, busy, done, in_ready}, 32'd0);
        tick; tick;
        chk("midrst.noaccept.Z", 32'(Z), 32'd0);
        chk("midrst.noaccept.busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        begin_burst(1);
        accept_op(16'h1234, 0, 1'b0, 1'b1);
        end_burst(1'b0);
        chk("afterrst.Z", 32'(Z), 32'h1234);

        // Stray start during ACC (with accepts and during a gap) and DONE
        begin_burst(3);
        accept_op(16'h0100, 0, 1'b1, 1'b0);
        start = 1'b1; len = 8'd1; in_valid = 1'b0;
        tick;
        chk("stray.gap.busy", 32'(busy), 32'd1);
        accept_op(16'h0200, 0, 1'b1, 1'b0);
        accept_op(16'h0300, 0, 1'b0, 1'b1);
        end_burst(1'b1);
        chk("stray.Z", 32'(Z), 32'h0600);
        tick;
        chk("stray.idle.busy", 32'(busy), 32'd0);

        // Random bursts against the model
        for (int b = 0; b < 25; b++) begin
            int l;
            l = $urandom_range(0, 10);
            begin_burst(l);
            for (int j = 0; j < l; j++) begin
                logic [15:0] op;
                case ($urandom_range(0, 5))
                    0: op = 16'h7FFF;
                    1: op = 16'h8000;
                    2: op = 16'hFFFF;
                    default: op = 16'($urandom);
                endcase
                accept_op(op, $urandom_range(0, 2), 1'($urandom_range(0, 1)), j == l - 1);
            end
            end_burst(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
